// File: rtl/lsu_issue_queue.sv
// In-order issue queue for the load/store unit.
// Entries are dispatched at the tail, woken up by the CDB, and issued only from the head.
// Optional feature: define LSU_ISSUE_QUEUE_CDB_BYPASS_EN so that a head waiting on the
// tag currently on the CDB can issue in that same cycle, using the broadcast value.
module lsu_issue_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       disp_valid_i,
  input  logic                       disp_mem_read_i,
  input  logic                       disp_rs1_rdy_i,
  input  logic [5:0]                 disp_rs1_tag_i,
  input  logic [31:0]                disp_rs1_val_i,
  input  logic [31:0]                disp_imm_i,
  input  logic [5:0]                 disp_rd_p_i,
  input  logic [5:0]                 disp_rob_tag_i,
  output logic                       disp_ready_o,
  input  logic                       cdb_valid_i,
  input  logic [5:0]                 cdb_tag_i,
  input  logic [31:0]                cdb_val_i,
  input  logic                       flush_i,
  output logic                       issue_valid_o,
  output logic                       issue_mem_read_o,
  output logic [31:0]                issue_rs1_val_o,
  output logic [31:0]                issue_imm_o,
  output logic [5:0]                 issue_rd_p_o,
  output logic [5:0]                 issue_rob_tag_o,
  input  logic                       fu_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              mem_read;
    logic              rs1_rdy;
    logic [TAG_W-1:0]  rs1_tag;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  rd_p;
    logic [TAG_W-1:0]  rob_tag;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DEPTH-1:0]  live_c;
  entry_t            head_ent_c;
  entry_t            disp_ent_c;
  logic              disp_fire_c;
  logic              issue_fire_c;
  logic              disp_cdb_hit_c;

  // Readiness to accept comes from the occupancy register only
  assign disp_ready_o = (count_q != CNT_W'(DEPTH));
  assign count_o      = count_q;
  assign head_ent_c   = ent_q[head_q];

  assign disp_fire_c  = disp_valid_i && disp_ready_o && !flush_i;
  assign issue_fire_c = issue_valid_o && fu_ready_i && !flush_i;

  // Mark entries that lie between head and head+count (circular)
  always_comb begin
    live_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live_c[i] = (CNT_W'(PTR_W'(PTR_W'(i) - head_q)) < count_q);
    end
  end

  // Build the incoming entry, capturing a same-cycle CDB broadcast of its source
  always_comb begin
    disp_cdb_hit_c      = !disp_rs1_rdy_i && cdb_valid_i && (cdb_tag_i == disp_rs1_tag_i);
    disp_ent_c          = '0;
    disp_ent_c.mem_read = disp_mem_read_i;
    disp_ent_c.rs1_rdy  = disp_rs1_rdy_i || disp_cdb_hit_c;
    disp_ent_c.rs1_tag  = disp_rs1_tag_i;
    disp_ent_c.rs1_val  = disp_cdb_hit_c ? cdb_val_i : disp_rs1_val_i;
    disp_ent_c.imm      = disp_imm_i;
    disp_ent_c.rd_p     = disp_rd_p_i;
    disp_ent_c.rob_tag  = disp_rob_tag_i;
  end

  // Head-side issue outputs; the bypass variant also looks at the live CDB
`ifdef LSU_ISSUE_QUEUE_CDB_BYPASS_EN
  logic head_cdb_hit_c;
  assign head_cdb_hit_c = !head_ent_c.rs1_rdy && cdb_valid_i && (cdb_tag_i == head_ent_c.rs1_tag);
  always_comb begin
    issue_valid_o   = !flush_i && (count_q != '0) && (head_ent_c.rs1_rdy || head_cdb_hit_c);
    issue_rs1_val_o = head_ent_c.rs1_rdy ? head_ent_c.rs1_val : cdb_val_i;
  end
`else
  always_comb begin
    issue_valid_o   = !flush_i && (count_q != '0) && head_ent_c.rs1_rdy;
    issue_rs1_val_o = head_ent_c.rs1_val;
  end
`endif

  assign issue_mem_read_o = head_ent_c.mem_read;
  assign issue_imm_o      = head_ent_c.imm;
  assign issue_rd_p_o     = head_ent_c.rd_p;
  assign issue_rob_tag_o  = head_ent_c.rob_tag;

  // Next entry contents: CDB wakeup of waiting live entries, then the tail write
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_c[i] && !ent_q[i].rs1_rdy && cdb_valid_i && (ent_q[i].rs1_tag == cdb_tag_i)) begin
        ent_d[i].rs1_rdy = 1'b1;
        ent_d[i].rs1_val = cdb_val_i;
      end
    end
    if (disp_fire_c) begin
      ent_d[tail_q] = disp_ent_c;
    end
  end

  // Next pointers and occupancy; flush empties the queue and drops any fire
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (disp_fire_c) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (issue_fire_c) begin
        head_d = head_q + PTR_W'(1);
      end
      unique case ({disp_fire_c, issue_fire_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Scoreboard bench for lsu_issue_queue: the stimulus pushes expected issues in
// program order, a negedge monitor pops and compares on every issue handshake.
module tb_lsu_issue_queue;

  logic        clk;
  logic        rst;
  logic        disp_valid_i;
  logic        disp_mem_read_i;
  logic        disp_rs1_rdy_i;
  logic [5:0]  disp_rs1_tag_i;
  logic [31:0] disp_rs1_val_i;
  logic [31:0] disp_imm_i;
  logic [5:0]  disp_rd_p_i;
  logic [5:0]  disp_rob_tag_i;
  logic        disp_ready_o;
  logic        cdb_valid_i;
  logic [5:0]  cdb_tag_i;
  logic [31:0] cdb_val_i;
  logic        flush_i;
  logic        issue_valid_o;
  logic        issue_mem_read_o;
  logic [31:0] issue_rs1_val_o;
  logic [31:0] issue_imm_o;
  logic [5:0]  issue_rd_p_o;
  logic [5:0]  issue_rob_tag_o;
  logic        fu_ready_i;
  logic [3:0]  count_o;

  lsu_issue_queue #(.DEPTH(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .disp_valid_i     (disp_valid_i),
    .disp_mem_read_i  (disp_mem_read_i),
    .disp_rs1_rdy_i   (disp_rs1_rdy_i),
    .disp_rs1_tag_i   (disp_rs1_tag_i),
    .disp_rs1_val_i   (disp_rs1_val_i),
    .disp_imm_i       (disp_imm_i),
    .disp_rd_p_i      (disp_rd_p_i),
    .disp_rob_tag_i   (disp_rob_tag_i),
    .disp_ready_o     (disp_ready_o),
    .cdb_valid_i      (cdb_valid_i),
    .cdb_tag_i        (cdb_tag_i),
    .cdb_val_i        (cdb_val_i),
    .flush_i          (flush_i),
    .issue_valid_o    (issue_valid_o),
    .issue_mem_read_o (issue_mem_read_o),
    .issue_rs1_val_o  (issue_rs1_val_o),
    .issue_imm_o      (issue_imm_o),
    .issue_rd_p_o     (issue_rd_p_o),
    .issue_rob_tag_o  (issue_rob_tag_o),
    .fu_ready_i       (fu_ready_i),
    .count_o          (count_o)
  );

  typedef struct {
    logic        mr;
    logic [31:0] val;
    logic [31:0] imm;
    logic [5:0]  rd;
    logic [5:0]  rob;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

`ifdef LSU_ISSUE_QUEUE_CDB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic rdy, input logic [5:0] tag, input logic [31:0] val,
                          input logic [31:0] imm, input logic [5:0] rd, input logic [5:0] rob);
    disp_valid_i    = 1'b1;
    disp_mem_read_i = 1'b1;
    disp_rs1_rdy_i  = rdy;
    disp_rs1_tag_i  = tag;
    disp_rs1_val_i  = val;
    disp_imm_i      = imm;
    disp_rd_p_i     = rd;
    disp_rob_tag_i  = rob;
  endtask

  task automatic push_exp(input logic [31:0] val, input logic [31:0] imm,
                          input logic [5:0] rd, input logic [5:0] rob);
    exp_t e;
    e.mr  = 1'b1;
    e.val = val;
    e.imm = imm;
    e.rd  = rd;
    e.rob = rob;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input string nm);
    int n;
    n = 0;
    while (count_o != 4'd0 && n < 50) begin
      cyc();
      n++;
    end
    chk(nm, 32'(count_o), 32'd0);
  endtask

  // Monitor: every issue handshake must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && issue_valid_o && fu_ready_i && !flush_i) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue: got rob 0x%0h expected no issue", issue_rob_tag_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_rs1_val", issue_rs1_val_o, e.val);
        chk("issue_imm", issue_imm_o, e.imm);
        chk("issue_rd_p", 32'(issue_rd_p_o), 32'(e.rd));
        chk("issue_rob_tag", 32'(issue_rob_tag_o), 32'(e.rob));
        chk("issue_mem_read", 32'(issue_mem_read_o), 32'(e.mr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0; fu_ready_i = 1'b0;
    disp_valid_i = 1'b0; disp_mem_read_i = 1'b0; disp_rs1_rdy_i = 1'b0;
    disp_rs1_tag_i = '0; disp_rs1_val_i = '0; disp_imm_i = '0; disp_rd_p_i = '0; disp_rob_tag_i = '0;
    cdb_valid_i = 1'b0; cdb_tag_i = '0; cdb_val_i = '0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_issue_valid", 32'(issue_valid_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_disp_ready", 32'(disp_ready_o), 32'd1);

    // Ready load issues exactly one cycle after dispatch
    cyc();
    fu_ready_i = 1'b1;
    set_disp(1'b1, 6'd0, 32'h100, 32'd4, 6'd10, 6'd3);
    push_exp(32'h100, 32'd4, 6'd10, 6'd3);
    #1;
    chk("s1_no_same_cycle_issue", 32'(issue_valid_o), 32'd0);
    cyc();
    disp_valid_i = 1'b0;
    #1;
    chk("s1_issue_valid", 32'(issue_valid_o), 32'd1);
    chk("s1_count_one", 32'(count_o), 32'd1);
    cyc();
    #1;
    chk("s1_count_back_zero", 32'(count_o), 32'd0);
    chk("s1_issue_valid_low", 32'(issue_valid_o), 32'd0);

    // Fill with unready entries; the ninth dispatch is dropped
    fu_ready_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_disp(1'b0, 6'd20, 32'd0, 32'(k), 6'd1, 6'(k));
      #1;
      chk("s2_ready_before_full", 32'(disp_ready_o), 32'd1);
      cyc();
    end
    #1;
    chk("s2_ready_low_full", 32'(disp_ready_o), 32'd0);
    chk("s2_count_full", 32'(count_o), 32'd8);
    cyc();
    disp_valid_i = 1'b0;
    #1;
    chk("s2_count_after_9th", 32'(count_o), 32'd8);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    #1;
    chk("s2_count_flushed", 32'(count_o), 32'd0);

    // Unready head blocks a ready younger entry until tag 5 is broadcast
    fu_ready_i = 1'b1;
    set_disp(1'b0, 6'd5, 32'd0, 32'h10, 6'd11, 6'd1);
    push_exp(32'hABCD, 32'h10, 6'd11, 6'd1);
    cyc();
    set_disp(1'b1, 6'd0, 32'h22, 32'h20, 6'd12, 6'd2);
    push_exp(32'h22, 32'h20, 6'd12, 6'd2);
    cyc();
    disp_valid_i = 1'b0;
    #1;
    chk("s3_head_blocks", 32'(issue_valid_o), 32'd0);
    chk("s3_count_two", 32'(count_o), 32'd2);
    cyc();
    cdb_valid_i = 1'b1; cdb_tag_i = 6'd5; cdb_val_i = 32'hABCD;
    #1;
    chk("s3_bcast_cycle_valid", 32'(issue_valid_o), 32'(BYPASS));
    cyc();
    cdb_valid_i = 1'b0;
    #1;
    chk("s3_next_cycle_valid", 32'(issue_valid_o), 32'd1);
    chk("s3_next_cycle_rob", 32'(issue_rob_tag_o), BYPASS ? 32'd2 : 32'd1);
    wait_empty("s3_drain");

    // Dispatch racing a CDB broadcast of its own source tag
    set_disp(1'b0, 6'd7, 32'd0, 32'h30, 6'd13, 6'd4);
    cdb_valid_i = 1'b1; cdb_tag_i = 6'd7; cdb_val_i = 32'h55;
    push_exp(32'h55, 32'h30, 6'd13, 6'd4);
    cyc();
    disp_valid_i = 1'b0; cdb_valid_i = 1'b0;
    #1;
    chk("s4_captured_valid", 32'(issue_valid_o), 32'd1);
    chk("s4_captured_val", issue_rs1_val_o, 32'h55);
    wait_empty("s4_drain");

    // Back-pressure: fields hold while fu_ready_i is low
    fu_ready_i = 1'b0;
    set_disp(1'b1, 6'd0, 32'h77, 32'd8, 6'd14, 6'd5);
    push_exp(32'h77, 32'd8, 6'd14, 6'd5);
    cyc();
    disp_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("s5_hold_valid", 32'(issue_valid_o), 32'd1);
      chk("s5_hold_val", issue_rs1_val_o, 32'h77);
      chk("s5_hold_rob", 32'(issue_rob_tag_o), 32'd5);
      cyc();
    end
    fu_ready_i = 1'b1;
    cyc();
    #1;
    chk("s5_count_zero", 32'(count_o), 32'd0);
    chk("s5_valid_low", 32'(issue_valid_o), 32'd0);

    // Flush with four queued, alongside a dispatch and a would-be fire
    fu_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_disp(1'b1, 6'd0, 32'h900 + 32'(k), 32'd0, 6'd2, 6'(40 + k));
      cyc();
    end
    disp_valid_i = 1'b0;
    #1;
    chk("s6_count_four", 32'(count_o), 32'd4);
    chk("s6_valid_before_flush", 32'(issue_valid_o), 32'd1);
    flush_i = 1'b1; fu_ready_i = 1'b1;
    set_disp(1'b1, 6'd0, 32'h999, 32'd0, 6'd2, 6'd50);
    #1;
    chk("s6_valid_forced_low", 32'(issue_valid_o), 32'd0);
    cyc();
    flush_i = 1'b0; disp_valid_i = 1'b0; fu_ready_i = 1'b0;
    #1;
    chk("s6_count_flushed", 32'(count_o), 32'd0);
    chk("s6_valid_flushed", 32'(issue_valid_o), 32'd0);

    // Twenty back-to-back dispatch/issue pairs across the pointer wrap
    cyc();
    fu_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_disp(1'b1, 6'd0, 32'h1000 + 32'(k), 32'(k * 3), 6'(k), 6'(k + 20));
      push_exp(32'h1000 + 32'(k), 32'(k * 3), 6'(k), 6'(k + 20));
      cyc();
    end
    disp_valid_i = 1'b0;
    wait_empty("s6_wrap_drain");
    cyc();
    chk("sb_all_issued", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_issue_queue.md
LSU_ISSUE_QUEUE -- requirements
Module: lsu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving the queue entry count; legal values are powers of two from 2 to 32.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port disp_valid_i  input  1  dispatch request from rename/dispatch.
REQ-005 SHALL have ports disp_mem_read_i (input, 1), disp_rs1_rdy_i (input, 1), disp_rs1_tag_i (input, 6), disp_rs1_val_i (input, 32), disp_imm_i (input, 32), disp_rd_p_i (input, 6) and disp_rob_tag_i (input, 6), carrying the dispatched memory-op fields; rs1_tag is the producer physical tag, and rs1_val is valid only when rs1_rdy is 1.
REQ-006 SHALL have port disp_ready_o  output  1  queue can accept a dispatch this cycle.
REQ-007 SHALL have ports cdb_valid_i (input, 1), cdb_tag_i (input, 6) and cdb_val_i (input, 32), carrying the common data bus broadcast.
REQ-008 SHALL have port flush_i  input  1  pipeline flush.
REQ-009 SHALL have ports issue_valid_o (output, 1), issue_mem_read_o (output, 1), issue_rs1_val_o (output, 32), issue_imm_o (output, 32), issue_rd_p_o (output, 6) and issue_rob_tag_o (output, 6), carrying the issue to the load/store unit.
REQ-010 SHALL have port fu_ready_i  input  1  load/store unit ready (its ready_o).
REQ-011 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-012 SHALL implement a circular FIFO of DEPTH entries; each entry holds mem_read, rs1_rdy, rs1_tag, rs1_val, imm, rd_p and rob_tag.
REQ-013 SHALL assert disp_ready_o = (count < DEPTH), derived from registered state only, with no combinational path from fu_ready_i or issue.
REQ-014 SHALL write the entry at the tail pointer and advance the tail on dispatch fire (disp_valid_i && disp_ready_o && !flush_i); disp_valid_i when full is ignored.
REQ-015 SHALL, on dispatch with disp_rs1_rdy_i = 0 while cdb_valid_i is high and cdb_tag_i == disp_rs1_tag_i in the same cycle, store the entry as rs1_rdy = 1 with rs1_val = cdb_val_i.
REQ-016 SHALL, on each cycle with cdb_valid_i high, set rs1_rdy = 1 and rs1_val = cdb_val_i in every valid entry with rs1_rdy = 0 and rs1_tag == cdb_tag_i.
REQ-017 SHALL issue strictly in program order: only the head entry may issue, and younger ready entries wait behind an unready head.
REQ-018 SHALL assert issue_valid_o when count > 0 and the head has rs1_rdy = 1 (extended by REQ-027); issue_* fields reflect the head.
REQ-019 SHALL, on issue fire (issue_valid_o && fu_ready_i && !flush_i), remove the head and advance the head pointer.
REQ-020 SHALL hold issue_valid_o and all issue_* fields stable until fire.
REQ-021 SHALL treat a fire on the same cycle as a dispatch as net count change 0, and support this when count is 0 < count < DEPTH.
REQ-022 SHALL give a minimum dispatch-to-issue_valid_o latency of 1 cycle: a dispatched entry is never issued in its dispatch cycle, even when the queue is empty.
REQ-023 SHALL wrap head and tail pointers modulo DEPTH; occupancy is tracked by a separate counter, not by pointer compare.
REQ-024 SHALL, when flush_i = 1, empty the queue on the next edge (head = tail = 0, count = 0); flush takes priority over a same-cycle dispatch or fire, which are dropped, and issue_valid_o is forced to 0 during flush_i.

Reset
REQ-025 SHALL, while rst is high at a clock edge, set head = 0, tail = 0, count = 0 and clear all entry rs1_rdy bits; rst overrides flush_i, dispatch and issue.
REQ-026 SHALL drive issue_valid_o = 0, count_o = 0 and disp_ready_o = 1 in the cycle after reset; issue_* data outputs are don't-care while issue_valid_o = 0.

Configuration
REQ-027 SHALL, with macro LSU_ISSUE_QUEUE_CDB_BYPASS_EN defined, also assert issue_valid_o when the head has rs1_rdy = 0 and cdb_valid_i && cdb_tag_i == head rs1_tag, driving issue_rs1_val_o = cdb_val_i; without the macro, such a head issues no earlier than the following cycle, and no output depends combinationally on cdb_*.

Verification
REQ-028 SHALL pass this scenario: reset, then dispatch a ready load (rs1_val = 0x100, imm = 4, rob_tag = 3) with fu_ready_i = 1 -> issue_valid_o is high exactly 1 cycle later with rs1_val 0x100 and imm 4, and count returns to 0.
REQ-029 SHALL pass this scenario: dispatch DEPTH = 8 unready entries -> disp_ready_o falls after the 8th, a 9th dispatch is ignored, and count_o = 8.
REQ-030 SHALL pass this scenario: the head waits on tag 5 and entry 1 is ready; broadcast tag 5 with value 0xABCD -> the head issues with 0xABCD before entry 1, with a 1-cycle bypass delta per macro.
REQ-031 SHALL pass this scenario: dispatch with rs1 tag 7 in the same cycle as a CDB broadcast of tag 7 with value 0x55 -> the entry later issues with 0x55 and does not hang.
REQ-032 SHALL pass this scenario: hold fu_ready_i = 0 for 3 cycles with the head ready -> issue fields stay stable, and the head issues once when fu_ready_i rises.
REQ-033 SHALL pass this scenario: flush_i asserted with count = 4, concurrent with a dispatch and a fire -> count = 0 and issue_valid_o = 0 next cycle; then run 20 dispatch/issue pairs to exercise pointer wrap and check issue order against dispatch order.
